// File: rtl/paddle_draw_sequencer.sv
// Per-frame paddle redraw sequencer: erases the old and draws the new left/right paddles as
// vertical-line jobs for the line drawer. Optional macro PADDLE_SKIP_UNCHANGED_EN skips unmoved paddles.
module paddle_draw_sequencer #(
  parameter int unsigned PADDLE_H = 32,
  parameter int unsigned PADDLE_W = 2,
  parameter int unsigned LEFT_X   = 10,
  parameter int unsigned RIGHT_X  = 308,
  parameter int unsigned SCREEN_H = 240
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic [7:0] left_y_req,
  input  logic [7:0] right_y_req,
  output logic       ln_start,
  input  logic       ln_done,
  output logic [8:0] ln_x,
  output logic [7:0] ln_y,
  output logic [7:0] ln_height,
  output logic       color,
  output logic       busy,
  output logic       frame_done,
  output logic       overrun
);

  localparam logic [7:0] Y_MAX    = 8'(SCREEN_H - PADDLE_H);
  localparam logic [8:0] LEFT_XB  = 9'(LEFT_X);
  localparam logic [8:0] RIGHT_XB = 9'(RIGHT_X);
  localparam logic [2:0] COL_LAST = 3'(PADDLE_W - 1);
  localparam logic [2:0] NO_JOB   = 3'd4;

  typedef enum logic [2:0] {IDLE, LATCH, ISSUE, RELEASE, NEXT, DONE} state_t;

  state_t     state_r;
  logic [7:0] old_left_r, old_right_r, new_left_r, new_right_r;
  logic       old_valid_r, skip_left_r, skip_right_r;
  logic [2:0] job_r, col_r;
  logic       ln_start_r, color_r, busy_r, frame_done_r, overrun_r;
  logic [8:0] ln_x_r;
  logic [7:0] ln_y_r;

  logic [7:0] clamp_left_s, clamp_right_s, cur_left_s, cur_right_s;
  logic       same_left_s, same_right_s;
  logic [2:0] latch_first_s, next_first_s, tgt_job_s, tgt_col_s;
  logic [8:0] tgt_x_s;
  logic [7:0] tgt_y_s;

  function automatic logic [7:0] clamp_y(input logic [7:0] y);
    if (y > Y_MAX) begin
      return Y_MAX;
    end else begin
      return y;
    end
  endfunction

  // Even jobs are erases; jobs 0/1 belong to the left paddle, 2/3 to the right.
  function automatic logic job_ok(input logic [2:0] j, input logic ov, input logic sl,
                                  input logic sr);
    logic ok;
    ok = 1'b1;
    if (!j[0] && !ov) ok = 1'b0;
    if ((j < 3'd2) && sl) ok = 1'b0;
    if ((j >= 3'd2) && sr) ok = 1'b0;
    return ok;
  endfunction

  function automatic logic [2:0] first_job(input logic [2:0] from, input logic ov,
                                           input logic sl, input logic sr);
    logic [2:0] res;
    res = NO_JOB;
    for (int k = 3; k >= 0; k--) begin
      if ((3'(k) >= from) && job_ok(3'(k), ov, sl, sr)) res = 3'(k);
    end
    return res;
  endfunction

  // Next-job selection and the drawer operands that job/column implies.
  always_comb begin
    clamp_left_s  = clamp_y(left_y_req);
    clamp_right_s = clamp_y(right_y_req);
`ifdef PADDLE_SKIP_UNCHANGED_EN
    same_left_s   = old_valid_r && (clamp_left_s == old_left_r);
    same_right_s  = old_valid_r && (clamp_right_s == old_right_r);
`else
    same_left_s   = 1'b0;
    same_right_s  = 1'b0;
`endif
    latch_first_s = first_job(3'd0, old_valid_r, same_left_s, same_right_s);
    next_first_s  = first_job(job_r + 3'd1, old_valid_r, skip_left_r, skip_right_r);
    if (state_r == LATCH) begin
      tgt_job_s   = latch_first_s;
      tgt_col_s   = 3'd0;
      cur_left_s  = clamp_left_s;
      cur_right_s = clamp_right_s;
    end else if (col_r < COL_LAST) begin
      tgt_job_s   = job_r;
      tgt_col_s   = col_r + 3'd1;
      cur_left_s  = new_left_r;
      cur_right_s = new_right_r;
    end else begin
      tgt_job_s   = next_first_s;
      tgt_col_s   = 3'd0;
      cur_left_s  = new_left_r;
      cur_right_s = new_right_r;
    end
    if (tgt_job_s < 3'd2) begin
      tgt_x_s = LEFT_XB + {6'd0, tgt_col_s};
    end else begin
      tgt_x_s = RIGHT_XB + {6'd0, tgt_col_s};
    end
    case (tgt_job_s)
      3'd0:    tgt_y_s = old_left_r;
      3'd1:    tgt_y_s = cur_left_s;
      3'd2:    tgt_y_s = old_right_r;
      default: tgt_y_s = cur_right_s;
    endcase
  end

  // Sequencer FSM with registered drawer and status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      old_left_r   <= 8'd0;
      old_right_r  <= 8'd0;
      new_left_r   <= 8'd0;
      new_right_r  <= 8'd0;
      old_valid_r  <= 1'b0;
      skip_left_r  <= 1'b0;
      skip_right_r <= 1'b0;
      job_r        <= 3'd0;
      col_r        <= 3'd0;
      ln_start_r   <= 1'b0;
      ln_x_r       <= 9'd0;
      ln_y_r       <= 8'd0;
      color_r      <= 1'b0;
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
      overrun_r    <= 1'b0;
    end else begin
      frame_done_r <= 1'b0;
      overrun_r    <= frame_tick && (state_r != IDLE);
      case (state_r)
        IDLE: begin
          if (frame_tick) begin
            state_r <= LATCH;
            busy_r  <= 1'b1;
          end
        end
        LATCH: begin
          new_left_r   <= clamp_left_s;
          new_right_r  <= clamp_right_s;
          skip_left_r  <= same_left_s;
          skip_right_r <= same_right_s;
          col_r        <= 3'd0;
          if (tgt_job_s == NO_JOB) begin
            state_r <= DONE;
          end else begin
            job_r      <= tgt_job_s;
            ln_x_r     <= tgt_x_s;
            ln_y_r     <= tgt_y_s;
            color_r    <= tgt_job_s[0];
            ln_start_r <= 1'b1;
            state_r    <= ISSUE;
          end
        end
        ISSUE: begin
          if (ln_done) begin
            ln_start_r <= 1'b0;
            state_r    <= RELEASE;
          end
        end
        RELEASE: state_r <= NEXT;
        NEXT: begin
          if (tgt_job_s == NO_JOB) begin
            col_r   <= 3'd0;
            state_r <= DONE;
          end else begin
            job_r      <= tgt_job_s;
            col_r      <= tgt_col_s;
            ln_x_r     <= tgt_x_s;
            ln_y_r     <= tgt_y_s;
            color_r    <= tgt_job_s[0];
            ln_start_r <= 1'b1;
            state_r    <= ISSUE;
          end
        end
        DONE: begin
          old_left_r   <= new_left_r;
          old_right_r  <= new_right_r;
          old_valid_r  <= 1'b1;
          frame_done_r <= 1'b1;
          busy_r       <= 1'b0;
          state_r      <= IDLE;
        end
        default: begin
          ln_start_r <= 1'b0;
          busy_r     <= 1'b0;
          state_r    <= IDLE;
        end
      endcase
    end
  end

  assign ln_start   = ln_start_r;
  assign ln_x       = ln_x_r;
  assign ln_y       = ln_y_r;
  assign ln_height  = 8'(PADDLE_H);
  assign color      = color_r;
  assign busy       = busy_r;
  assign frame_done = frame_done_r;
  assign overrun    = overrun_r;

endmodule

// File: tb/tb_paddle_draw_sequencer.sv
// Directed bench for paddle_draw_sequencer with a line-drawer model that answers each job after 31 cycles.
module tb_paddle_draw_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic [7:0] left_y_req = 8'd0;
  logic [7:0] right_y_req = 8'd0;
  logic       ln_start;
  logic       ln_done = 1'b0;
  logic [8:0] ln_x;
  logic [7:0] ln_y;
  logic [7:0] ln_height;
  logic       color;
  logic       busy;
  logic       frame_done;
  logic       overrun;

  int n_cmp = 0;
  int n_err = 0;
  int got_x[$], got_y[$], got_c[$];
  int exp_x[$], exp_y[$], exp_c[$];
  int fd_cnt = 0, ov_cnt = 0, stab_err = 0, gap_err = 0;

  paddle_draw_sequencer dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick),
    .left_y_req(left_y_req), .right_y_req(right_y_req),
    .ln_start(ln_start), .ln_done(ln_done), .ln_x(ln_x), .ln_y(ln_y),
    .ln_height(ln_height), .color(color), .busy(busy),
    .frame_done(frame_done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input int obs, input int expv);
    n_cmp++;
    if (obs != expv) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, expv);
    end
  endtask

  // Drawer model plus job log, handshake-stability and gap monitors.
  initial begin
    int cnt = 0;
    int low = 100;
    bit served = 1'b0;
    bit prev = 1'b0;
    int px = 0, py = 0, pc = 0;
    forever begin
      @(negedge clk);
      ln_done = 1'b0;
      if (frame_done) fd_cnt++;
      if (overrun) ov_cnt++;
      if (ln_start) begin
        if (!prev) begin
          got_x.push_back(int'(ln_x));
          got_y.push_back(int'(ln_y));
          got_c.push_back(int'(color));
          if (low < 2) gap_err++;
        end else if (int'(ln_x) != px || int'(ln_y) != py || int'(color) != pc) begin
          stab_err++;
        end
        low = 0;
        if (!served) begin
          cnt++;
          if (cnt == 31) begin
            ln_done = 1'b1;
            served = 1'b1;
          end
        end
      end else begin
        low++;
        cnt = 0;
        served = 1'b0;
      end
      prev = ln_start;
      px = int'(ln_x);
      py = int'(ln_y);
      pc = int'(color);
    end
  end

  task automatic expect_job(input int x, input int y, input int c);
    exp_x.push_back(x);
    exp_y.push_back(y);
    exp_c.push_back(c);
  endtask

  task automatic compare_jobs(input string tag);
    check_value({tag, "_njobs"}, got_x.size(), exp_x.size());
    for (int i = 0; i < exp_x.size(); i++) begin
      if (i < got_x.size()) begin
        check_value($sformatf("%s_x%0d", tag, i), got_x[i], exp_x[i]);
        check_value($sformatf("%s_y%0d", tag, i), got_y[i], exp_y[i]);
        check_value($sformatf("%s_c%0d", tag, i), got_c[i], exp_c[i]);
      end
    end
    got_x.delete(); got_y.delete(); got_c.delete();
    exp_x.delete(); exp_y.delete(); exp_c.delete();
  endtask

  task automatic pulse_tick(input logic [7:0] l, input logic [7:0] r);
    @(negedge clk);
    left_y_req = l;
    right_y_req = r;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic wait_frame_done(input string tag);
    int start;
    int n;
    start = fd_cnt;
    n = 0;
    while (fd_cnt == start && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check_value({tag, "_done_seen"}, int'(fd_cnt != start), 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_jobs(input int k, input string tag);
    int n;
    n = 0;
    while (got_x.size() < k && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check_value({tag, "_reached"}, int'(got_x.size() >= k), 1);
  endtask

  initial begin
    int fd0, ov0, lat;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_value("rst_ln_start", int'(ln_start), 0);
    check_value("rst_busy", int'(busy), 0);
    check_value("rst_color", int'(color), 0);
    check_value("rst_frame_done", int'(frame_done), 0);
    check_value("rst_overrun", int'(overrun), 0);
    check_value("rst_ln_x", int'(ln_x), 0);
    check_value("rst_ln_y", int'(ln_y), 0);
    check_value("ln_height", int'(ln_height), 32);

    // Frame 1: draws only.
    pulse_tick(8'd50, 8'd100);
    check_value("f1_busy", int'(busy), 1);
    wait_frame_done("f1");
    check_value("f1_busy_after", int'(busy), 0);
    expect_job(10, 50, 1); expect_job(11, 50, 1);
    expect_job(308, 100, 1); expect_job(309, 100, 1);
    compare_jobs("f1");

    // Frame 2: left moves, right stays.
    pulse_tick(8'd60, 8'd100);
    wait_frame_done("f2");
    expect_job(10, 50, 0); expect_job(11, 50, 0);
    expect_job(10, 60, 1); expect_job(11, 60, 1);
`ifndef PADDLE_SKIP_UNCHANGED_EN
    expect_job(308, 100, 0); expect_job(309, 100, 0);
    expect_job(308, 100, 1); expect_job(309, 100, 1);
`endif
    compare_jobs("f2");

    // Frame 3: both requests clamp to Y_MAX = 208.
    pulse_tick(8'd230, 8'd255);
    wait_frame_done("f3");
    expect_job(10, 60, 0); expect_job(11, 60, 0);
    expect_job(10, 208, 1); expect_job(11, 208, 1);
    expect_job(308, 100, 0); expect_job(309, 100, 0);
    expect_job(308, 208, 1); expect_job(309, 208, 1);
    compare_jobs("f3");

    // Frame 4: frame_tick during the second job.
    fd0 = fd_cnt;
    ov0 = ov_cnt;
    pulse_tick(8'd20, 8'd40);
    wait_jobs(2, "f4_job2");
    pulse_tick(8'd99, 8'd99);
    wait_frame_done("f4");
    repeat (100) @(negedge clk);
    check_value("f4_overrun_cnt", ov_cnt - ov0, 1);
    check_value("f4_frame_done_cnt", fd_cnt - fd0, 1);
    expect_job(10, 208, 0); expect_job(11, 208, 0);
    expect_job(10, 20, 1); expect_job(11, 20, 1);
    expect_job(308, 208, 0); expect_job(309, 208, 0);
    expect_job(308, 40, 1); expect_job(309, 40, 1);
    compare_jobs("f4");

    // Frame 5: reset during the third job.
    pulse_tick(8'd70, 8'd80);
    wait_jobs(3, "f5_job3");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_value("f5_rst_ln_start", int'(ln_start), 0);
    check_value("f5_rst_busy", int'(busy), 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    got_x.delete(); got_y.delete(); got_c.delete();

    // Frame 6: after reset, draws only.
    pulse_tick(8'd90, 8'd110);
    wait_frame_done("f6");
    expect_job(10, 90, 1); expect_job(11, 90, 1);
    expect_job(308, 110, 1); expect_job(309, 110, 1);
    compare_jobs("f6");

    // Frame 7: same positions again.
    @(negedge clk);
    left_y_req = 8'd90;
    right_y_req = 8'd110;
    frame_tick = 1'b1;
    lat = 0;
    for (int k = 1; k <= 5000 && lat == 0; k++) begin
      @(negedge clk);
      frame_tick = 1'b0;
      if (frame_done) lat = k;
    end
    repeat (3) @(negedge clk);
`ifdef PADDLE_SKIP_UNCHANGED_EN
    check_value("f7_done_latency", lat, 3);
`else
    check_value("f7_done_seen", int'(lat != 0), 1);
    expect_job(10, 90, 0); expect_job(11, 90, 0);
    expect_job(10, 90, 1); expect_job(11, 90, 1);
    expect_job(308, 110, 0); expect_job(309, 110, 0);
    expect_job(308, 110, 1); expect_job(309, 110, 1);
`endif
    compare_jobs("f7");

    check_value("stable_while_start", stab_err, 0);
    check_value("low_gap_ge2", gap_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
